axis_width_convert_keep: RTL

//  AXI-stream data-width converter with byte-enable (tkeep) and packet (tlast) awareness.

---
 rtl/axis_width_convert_keep_if.sv | 24 ++
 rtl/axis_width_convert_keep.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_convert_keep_if.sv
// ---------------------------------------------------------------------------
// axis_width_convert_keep_if
// AXI-stream bundle carrying data, byte enables and packet boundary.
//   tdata  [WIDTH-1:0]    payload, little-endian byte order
//   tkeep  [WIDTH/8-1:0]  byte enables, contiguous from LSB
//   tvalid                source has a beat
//   tlast                 beat ends a packet
//   tready                sink accepts the beat
// Modports: master (drives the stream), slave (consumes it).
// ---------------------------------------------------------------------------
interface axis_width_convert_keep_if #(
   parameter int WIDTH = 32
);
   localparam int KW = WIDTH / 8;

   logic [WIDTH-1:0] tdata;
   logic [KW-1:0]    tkeep;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport master (output tdata, tkeep, tvalid, tlast, input  tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_width_convert_keep.sv
// ---------------------------------------------------------------------------
// axis_width_convert_keep
// AXI-stream width converter aware of tkeep and tlast.
//   up-size   (OSIZE = RATIO*ISIZE): packs RATIO beats per word, closes a short
//                                    group early on tlast and zero-fills it.
//   down-size (ISIZE = RATIO*OSIZE): splits each beat into slices, skipping
//                                    empty trailing slices after tlast.
//   equal widths                   : single register slice.
// Ports
//   clock     in   sole clock
//   rst       in   synchronous, active-high reset
//   in_axis   slave  modport, ISIZE-bit stream in
//   out_axis  master modport, OSIZE-bit stream out
// Earliest narrow beat/slice sits in the LSBs of the wide word.
// ---------------------------------------------------------------------------
module axis_width_convert_keep #(
   parameter int ISIZE = 32,
   parameter int OSIZE = 128
) (
   input  logic                      clock,
   input  logic                      rst,
   axis_width_convert_keep_if.slave  in_axis,
   axis_width_convert_keep_if.master out_axis
);
   localparam int RATIO = (ISIZE > OSIZE) ? ISIZE / OSIZE : OSIZE / ISIZE;
   localparam int IB    = ISIZE / 8;
   localparam int OB    = OSIZE / 8;

   if ((ISIZE % 8) != 0 || (OSIZE % 8) != 0 ||
       ((ISIZE > OSIZE) ? (ISIZE % OSIZE) : (OSIZE % ISIZE)) != 0) begin : g_bad_params
      $error("axis_width_convert_keep: widths must be byte multiples with an integer ratio");
   end

   if (ISIZE == OSIZE) begin : g_pass
      logic [OSIZE-1:0] out_data;
      logic [OB-1:0]    out_keep;
      logic             out_valid;
      logic             out_last;
      logic             in_fire;

      assign in_axis.tready = !rst && (!out_valid || out_axis.tready);
      assign in_fire        = in_axis.tvalid && in_axis.tready;

      always_ff @(posedge clock) begin
         // NOTE: output/holding registers are reset explicitly so the port
         // values are defined zeros right after rst, not just invalid.
         if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (in_fire) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            out_data  <= in_axis.tdata;
            out_keep  <= in_axis.tkeep;
            out_last  <= in_axis.tlast;
            out_valid <= 1'b1;
         end else if (out_axis.tready) begin
            out_valid <= 1'b0;
         end
      end

      assign out_axis.tdata  = out_data;
      assign out_axis.tkeep  = out_keep;
      assign out_axis.tvalid = out_valid;
      assign out_axis.tlast  = out_last;

   end else if (OSIZE > ISIZE) begin : g_up
      localparam int            CW        = $clog2(RATIO);
      localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

      logic [OSIZE-1:0] acc_data, merge_data, out_data;
      logic [OB-1:0]    acc_keep, merge_keep, out_keep;
      logic [CW-1:0]    cnt;
      logic             out_valid, out_last;
      logic             closing, in_fire, out_fire;

      // A beat closes the group when it fills the last lane or ends the packet.
      assign closing  = (cnt == LAST_LANE) || in_axis.tlast;
      assign out_fire = out_valid && out_axis.tready;
      // Only a closing beat needs the output register; others always fit.
      assign in_axis.tready = !rst && !(out_valid && !out_axis.tready && closing);
      assign in_fire        = in_axis.tvalid && in_axis.tready;

      // Accumulator with the incoming beat dropped into lane cnt. Lanes above
      // cnt are still zero because the accumulator is cleared on every close.
      always_comb begin
         // NOTE: defaults first, so no path leaves a value unassigned and no
         // latch is inferred.
         merge_data = acc_data;
         merge_keep = acc_keep;
         for (int i = 0; i < RATIO; i++) begin
            if (cnt == CW'(i)) begin
               merge_data[i*ISIZE +: ISIZE] = in_axis.tdata;
               merge_keep[i*IB +: IB]       = in_axis.tkeep;
            end
         end
      end

      always_ff @(posedge clock) begin
         if (rst) begin
            acc_data  <= '0;
            acc_keep  <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            if (out_fire) out_valid <= 1'b0;
            if (in_fire) begin
               if (closing) begin
                  out_data  <= merge_data;
                  out_keep  <= merge_keep;
                  out_last  <= in_axis.tlast;
                  out_valid <= 1'b1;
                  acc_data  <= '0;
                  acc_keep  <= '0;
                  cnt       <= '0;
               end else begin
                  acc_data  <= merge_data;
                  acc_keep  <= merge_keep;
                  cnt       <= cnt + 1'b1;
               end
            end
         end
      end

      assign out_axis.tdata  = out_data;
      assign out_axis.tkeep  = out_keep;
      assign out_axis.tvalid = out_valid;
      assign out_axis.tlast  = out_last;

   end else begin : g_down
      typedef enum logic {IDLE, SEND} state_t;

      localparam int            CW       = $clog2(RATIO);
      localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

      state_t           state, state_nxt;
      logic [CW-1:0]    idx, idx_nxt;
      logic [ISIZE-1:0] hold_data;
      logic [IB-1:0]    hold_keep;
      logic             hold_last;
      logic [OSIZE-1:0] slice_data;
      logic [OB-1:0]    slice_keep, next_keep;
      logic             is_final, load, in_ready, in_fire, out_fire;

      // Current slice and the keep of the slice after it.
      always_comb begin
         slice_data = '0;
         slice_keep = '0;
         next_keep  = '0;
         for (int i = 0; i < RATIO; i++) begin
            if (idx == CW'(i)) begin
               slice_data = hold_data[i*OSIZE +: OSIZE];
               slice_keep = hold_keep[i*OB +: OB];
            end
         end
         for (int i = 1; i < RATIO; i++) begin
            if (idx == CW'(i - 1)) next_keep = hold_keep[i*OB +: OB];
         end
      end

      // Empty slices after tlast are skipped; a non-last beat emits all slices.
      assign is_final = (idx == LAST_IDX) || (hold_last && (next_keep == '0));
      assign out_fire = (state == SEND) && out_axis.tready;
      // Accepting on the final slice lets the hold register reload gap-free.
      assign in_ready = !rst && ((state == IDLE) || (out_axis.tready && is_final));
      assign in_fire  = in_axis.tvalid && in_ready;
      assign in_axis.tready = in_ready;

      always_comb begin
         state_nxt = state;
         idx_nxt   = idx;
         load      = 1'b0;
         case (state)
            IDLE: begin
               if (in_fire) begin
                  load      = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = SEND;
               end
            end
            SEND: begin
               if (out_fire) begin
                  if (!is_final) begin
                     idx_nxt = idx + 1'b1;
                  end else if (in_fire) begin
                     load    = 1'b1;
                     idx_nxt = '0;
                  end else begin
                     idx_nxt   = '0;
                     state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      always_ff @(posedge clock) begin
         if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            hold_data <= '0;
            hold_keep <= '0;
            hold_last <= 1'b0;
         end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
               hold_data <= in_axis.tdata;
               hold_keep <= in_axis.tkeep;
               hold_last <= in_axis.tlast;
            end
         end
      end

      assign out_axis.tdata  = slice_data;
      assign out_axis.tkeep  = slice_keep;
      assign out_axis.tvalid = (state == SEND);
      assign out_axis.tlast  = (state == SEND) && hold_last && is_final;
   end
endmodule
